// File: rtl/spi_frame_tx.sv
// Streams one WIDTH x HEIGHT frame of 16-bit pixels from a synchronous frame store
// out over a two-wire SPI link, MSB first, with no gaps between bits or pixels.
module spi_frame_tx #(
  parameter int WIDTH   = 64,
  parameter int HEIGHT  = 32,
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [15:0]       pixel_data,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic [1:0]        dbg_state
);

  localparam int HALF_W = $clog2(CLK_DIV) + 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [15:0]         shreg_q, shreg_d;
  logic [15:0]         hold_q, hold_d;
  logic [3:0]          bit_q, bit_d;
  logic                phase_q, phase_d;   // 0 = low half of the bit, 1 = high half
  logic [HALF_W-1:0]   half_q, half_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [1:0]          cap_cnt_q, cap_cnt_d;
  logic [ADDR_W-1:0]   next_pix;

  assign next_pix = pix_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    half_d    = half_q;
    pix_d     = pix_q;
    cap_cnt_d = cap_cnt_q;

    // Holding register samples the store two edges after the address moved,
    // which suits both registered and combinational read ports.
    if (cap_cnt_q != 2'd0) begin
      cap_cnt_d = cap_cnt_q - 2'd1;
      if (cap_cnt_q == 2'd1) hold_d = pixel_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        shreg_d   = pixel_data;
        mosi_d    = pixel_data[15];
        bit_d     = 4'd15;
        phase_d   = 1'b0;
        half_d    = '0;
        addr_d    = ADDR_W'(1);
        pix_d     = '0;
        cap_cnt_d = 2'd2;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + HALF_W'(1);
        end else begin
          half_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q != 4'd0) begin
              bit_d  = bit_q - 4'd1;
              mosi_d = shreg_q[bit_q - 4'd1];
            end else if (pix_q != PIX_LAST) begin
              shreg_d   = hold_q;
              mosi_d    = hold_q[15];
              bit_d     = 4'd15;
              pix_d     = next_pix;
              addr_d    = (next_pix == PIX_LAST) ? PIX_LAST : next_pix + ADDR_W'(1);
              cap_cnt_d = 2'd2;
            end else begin
              // Rewinding the address lets a registered store present pixel 0
              // by the time a following FETCH samples it.
              mosi_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              addr_d  = '0;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      shreg_q   <= '0;
      hold_q    <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      half_q    <= '0;
      pix_q     <= '0;
      cap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      half_q    <= half_d;
      pix_q     <= pix_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pixel_addr = addr_q;
  assign spi_clk    = sclk_q;
  assign spi_mosi   = mosi_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed sequence of frame transfers on a reduced 8x4 frame; an SPI sampling
// monitor rebuilds the pixel words, which are compared with the frame store contents.
module tb_spi_frame_tx;

  localparam int W         = 8;
  localparam int H         = 4;
  localparam int CD        = 2;
  localparam int AW        = 5;
  localparam int NPIX      = W * H;
  localparam int FRAME_CYC = NPIX * 32 * CD;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, spi_clk, spi_mosi;
  logic [AW-1:0] pixel_addr;
  logic [15:0]   pixel_data;
  logic [1:0]    dbg_state;
  logic [15:0]   mem [NPIX];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // ---------------- clock / frame store ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) pixel_data <= mem[pixel_addr];

  spi_frame_tx #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(CD), .ADDR_W(AW)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pixel_addr (pixel_addr),
    .pixel_data (pixel_data),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .dbg_state  (dbg_state)
  );

  // ---------------- SPI sampling monitor ----------------
  int   rise_cnt = 0;
  bit   bits_q[$];
  int   rise_t_q[$];
  int   hold_viol = 0, setup_viol = 0, high_viol = 0;
  int   mosi_age = 0, high_len = 0;
  logic prev_sclk = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (spi_mosi !== prev_mosi) begin
      mosi_age = 1;
      if (spi_clk === 1'b1) hold_viol++;
    end else begin
      mosi_age++;
    end
    if (spi_clk === 1'b1 && prev_sclk !== 1'b1) begin
      rise_cnt++;
      bits_q.push_back(spi_mosi);
      rise_t_q.push_back(cyc);
      if (mosi_age < CD + 1) setup_viol++;
      high_len = 1;
    end else if (spi_clk === 1'b1) begin
      high_len++;
    end
    if (spi_clk !== 1'b1 && prev_sclk === 1'b1 && n_reset === 1'b1 && high_len != CD)
      high_viol++;
    prev_sclk = spi_clk;
    prev_mosi = spi_mosi;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt = 0;
    bits_q.delete();
    rise_t_q.delete();
    hold_viol  = 0;
    setup_viol = 0;
    high_viol  = 0;
  endtask

  // Called at a negedge; start is sampled by the next rising edge (E0).
  task automatic start_frame(input string tag, input logic [1:0] idle_state, output int e1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " e0_busy"}, busy, 1);
    check({tag, " e0_addr"}, pixel_addr, 0);
    check({tag, " e0_state_left_idle"}, dbg_state != idle_state, 1);
    e1 = cyc + 1;
    @(negedge clk);
    check({tag, " e1_mosi"}, spi_mosi, mem[0][15]);
    check({tag, " e1_sclk"}, spi_clk, 0);
  endtask

  task automatic wait_done(input string tag, input bit jitter, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < FRAME_CYC + 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        start    = 1'b0;
        done_cyc = cyc;
        break;
      end
      start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check({tag, " done_seen"}, done_cyc >= 0, 1);
  endtask

  // Reference: the stream is every pixel of the store in address order, 16 bits each, MSB first.
  task automatic check_frame(input string tag, input int e1, input int done_cyc);
    int bad_gap;
    logic [15:0] w;
    bad_gap = 0;
    check({tag, " done_latency"}, done_cyc - e1, FRAME_CYC);
    check({tag, " rises"}, rise_cnt, NPIX * 16);
    for (int k = 0; k < NPIX; k++) begin
      w = '0;
      for (int b = 0; b < 16; b++)
        if (k * 16 + b < bits_q.size()) w = {w[14:0], bits_q[k * 16 + b]};
      check($sformatf("%s word%0d", tag, k), w, mem[k]);
    end
    for (int i = 1; i < rise_t_q.size(); i++)
      if (rise_t_q[i] - rise_t_q[i-1] != 2 * CD) bad_gap++;
    check({tag, " rise_spacing_errors"}, bad_gap, 0);
    check({tag, " mosi_change_while_high"}, hold_viol, 0);
    check({tag, " mosi_setup_errors"}, setup_viol, 0);
    check({tag, " high_phase_errors"}, high_viol, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e1, dc, last_rise, busy_seen, waited;
    logic [1:0] idle_state;

    for (int i = 0; i < NPIX; i++) mem[i] = 16'(i);

    // Reset values
    repeat (5) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst addr", pixel_addr, 0);
    check("rst sclk", spi_clk, 0);
    check("rst mosi", spi_mosi, 0);
    idle_state = dbg_state;

    n_reset = 1'b1;
    clear_mon();
    busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) busy_seen++;
    end
    check("idle busy_or_done", busy_seen, 0);
    check("idle rises", rise_cnt, 0);

    // Ramp frame: data[i] = i
    clear_mon();
    start_frame("ramp", idle_state, e1);
    wait_done("ramp", 1'b0, dc);
    check_frame("ramp", e1, dc);
    @(negedge clk);
    check("ramp done_one_cycle", done, 0);
    check("ramp busy_after", busy, 0);
    check("ramp state_idle", dbg_state, idle_state);

    // Random frame with start toggling while busy: must still be one frame
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    clear_mon();
    start_frame("jitter", idle_state, e1);
    wait_done("jitter", 1'b1, dc);
    check_frame("jitter", e1, dc);
    repeat (200) @(negedge clk);
    check("jitter no_second_frame", rise_cnt, NPIX * 16);
    check("jitter idle_busy", busy, 0);

    // Back-to-back: start asserted during the done cycle
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    clear_mon();
    start_frame("b2b_a", idle_state, e1);
    wait_done("b2b_a", 1'b0, dc);
    check_frame("b2b_a", e1, dc);
    last_rise = (rise_t_q.size() > 0) ? rise_t_q[$] : 0;
    clear_mon();
    start_frame("b2b_b", idle_state, e1);
    wait_done("b2b_b", 1'b0, dc);
    check_frame("b2b_b", e1, dc);
    check("b2b rise_gap", (rise_t_q.size() > 0) ? rise_t_q[0] - last_rise : -1, 2 * CD + 2);

    // Mid-frame asynchronous reset
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    clear_mon();
    start_frame("midrst", idle_state, e1);
    waited = 0;
    while (rise_cnt < 300 && waited < FRAME_CYC) begin
      @(negedge clk);
      waited++;
    end
    check("midrst reached_300_rises", rise_cnt >= 300, 1);
    n_reset = 1'b0;
    #1;
    check("midrst sclk", spi_clk, 0);
    check("midrst mosi", spi_mosi, 0);
    check("midrst busy", busy, 0);
    check("midrst addr", pixel_addr, 0);
    check("midrst done", done, 0);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    start_frame("after_rst", idle_state, e1);
    wait_done("after_rst", 1'b0, dc);
    check_frame("after_rst", e1, dc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
